tlb_set_assoc_array: RTL and testbench



---
 rtl/tlb_set_assoc_array.sv | 170 +++++++++++++++++
 tb/tb_tlb_set_assoc_array.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tlb_set_assoc_array.sv
// tlb_set_assoc_array: parametrised set-associative TLB array with lookup, fill and SFENCE-style flush
module tlb_set_assoc_array #(
  parameter int ENTRIES    = 32,
  parameter int ASSOC      = 2,
  parameter int SUPERPAGE  = 0,
  parameter int ASID_WIDTH = 9,
  parameter int PERM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [19:0]           req_vpn,
  input  logic [ASID_WIDTH-1:0] req_asid,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [21:0]           resp_ppn,
  output logic [PERM_WIDTH-1:0] resp_perms,
  input  logic                  fill_valid,
  input  logic [19:0]           fill_vpn,
  input  logic [ASID_WIDTH-1:0] fill_asid,
  input  logic [21:0]           fill_ppn,
  input  logic [PERM_WIDTH-1:0] fill_perms,
  input  logic                  fill_global,
  input  logic                  flush_valid,
  output logic                  flush_ready,
  input  logic [1:0]            flush_mode,
  input  logic [19:0]           flush_vpn,
  input  logic [ASID_WIDTH-1:0] flush_asid,
  output logic                  flush_done
);
  localparam int NUM_SETS = ENTRIES / ASSOC;
  localparam int IB = $clog2(NUM_SETS);
  localparam int IW = IB > 0 ? IB : 1;
  localparam int WW = ASSOC > 1 ? $clog2(ASSOC) : 1;
  localparam int KW = SUPERPAGE != 0 ? 10 : 20;
  localparam int TW = KW - IB;
  typedef enum logic {IDLE, FLUSH_WALK} state_t;
  state_t state, state_d;
  logic [ENTRIES-1:0] valid, valid_d, clr, fill_hot;
  logic glob [ENTRIES];
  logic [ASID_WIDTH-1:0] asid [ENTRIES];
  logic [TW-1:0] tag [ENTRIES];
  logic [21:0] ppn [ENTRIES];
  logic [PERM_WIDTH-1:0] perms [ENTRIES];
  logic [WW-1:0] rr [NUM_SETS];
  logic [IW-1:0] cnt, rs, fs, xs;
  logic [TW-1:0] rt, ft, xt;
  logic [ASID_WIDTH-1:0] walk_asid;
  logic idle, fl_acc, fill_do, walk_last, hit, fmatch, finv, use_rr;
  logic [21:0] hppn;
  logic [PERM_WIDTH-1:0] hperm;
  logic [WW-1:0] fway;

  function automatic logic [IW-1:0] set_of(input logic [19:0] vpn);
    logic [KW-1:0] k;
    k = vpn[19 -: KW];
    return IW'(k % NUM_SETS);
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [19:0] vpn);
    logic [KW-1:0] k;
    k = vpn[19 -: KW];
    return k[KW-1 -: TW];
  endfunction

  function automatic int ent(input logic [IW-1:0] s, input int w);
    return int'(s) * ASSOC + w;
  endfunction

  assign rs = set_of(req_vpn);
  assign rt = tag_of(req_vpn);
  assign fs = set_of(fill_vpn);
  assign ft = tag_of(fill_vpn);
  assign xs = set_of(flush_vpn);
  assign xt = tag_of(flush_vpn);
  assign idle = state == IDLE;
  assign req_ready = idle;
  assign flush_ready = idle;
  assign fl_acc = flush_valid && idle;
  assign fill_do = fill_valid && idle && !flush_valid;
  assign walk_last = cnt == IW'(NUM_SETS - 1);

  // lookup compare against the indexed set, pre-update contents
  always_comb begin
    hit = 1'b0;
    hppn = '0;
    hperm = '0;
    for (int w = 0; w < ASSOC; w++)
      if (valid[ent(rs, w)] && tag[ent(rs, w)] == rt && (glob[ent(rs, w)] || asid[ent(rs, w)] == req_asid)) begin
        hit = 1'b1;
        hppn = ppn[ent(rs, w)];
        hperm = perms[ent(rs, w)];
      end
  end

  // fill victim: matching way, else lowest invalid way, else round-robin pointer
  always_comb begin
    fmatch = 1'b0;
    finv = 1'b0;
    fway = '0;
    for (int w = ASSOC - 1; w >= 0; w--)
      if (!valid[ent(fs, w)]) begin
        finv = 1'b1;
        fway = WW'(w);
      end
    for (int w = 0; w < ASSOC; w++)
      if (valid[ent(fs, w)] && tag[ent(fs, w)] == ft && (glob[ent(fs, w)] || asid[ent(fs, w)] == fill_asid)) begin
        fmatch = 1'b1;
        fway = WW'(w);
      end
    use_rr = !fmatch && !finv;
    if (use_rr) fway = rr[fs];
  end

  // per-entry invalidation from direct flushes and the ASID walk, merged with the fill
  always_comb begin
    clr = '0;
    fill_hot = '0;
    for (int e = 0; e < ENTRIES; e++)
      clr[e] = (fl_acc && (flush_mode == 2'd0 || (flush_mode[0] && IW'(e / ASSOC) == xs && tag[e] == xt &&
               (!flush_mode[1] || (!glob[e] && asid[e] == flush_asid))))) ||
               (!idle && IW'(e / ASSOC) == cnt && !glob[e] && asid[e] == walk_asid);
    fill_hot[ent(fs, int'(fway))] = fill_do;
    valid_d = (valid & ~clr) | fill_hot;
  end

  // next state: enter the walk on an ASID flush, leave after the last set
  always_comb begin
    state_d = state;
    if (fl_acc && flush_mode == 2'd2) state_d = FLUSH_WALK;
    else if (!idle && walk_last) state_d = IDLE;
  end

  // control state, valid bits, replacement pointers and registered response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      valid <= '0;
      walk_asid <= '0;
      flush_done <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_ppn <= '0;
      resp_perms <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr[s] <= '0;
    end else begin
      state <= state_d;
      valid <= valid_d;
      cnt <= idle ? '0 : cnt + 1'b1;
      if (fl_acc) walk_asid <= flush_asid;
      flush_done <= (fl_acc && flush_mode != 2'd2) || (!idle && walk_last);
      if (fill_do && use_rr) rr[fs] <= ASSOC > 1 ? fway + 1'b1 : '0;
      resp_valid <= req_valid && idle;
      resp_hit <= req_valid && idle && hit;
      resp_ppn <= (req_valid && idle && hit) ? (SUPERPAGE != 0 ? {hppn[21:10], req_vpn[9:0]} : hppn) : '0;
      resp_perms <= (req_valid && idle && hit) ? hperm : '0;
    end

  // translation payload, written only by fills
  always_ff @(posedge clk)
    if (fill_do) begin
      glob[ent(fs, int'(fway))] <= fill_global;
      asid[ent(fs, int'(fway))] <= fill_asid;
      tag[ent(fs, int'(fway))] <= ft;
      ppn[ent(fs, int'(fway))] <= fill_ppn;
      perms[ent(fs, int'(fway))] <= fill_perms;
    end
endmodule

// File: tb/tb_tlb_set_assoc_array.sv
// tb_tlb_set_assoc_array: scoreboard bench for a 32-entry 2-way TLB and a 4-entry megapage TLB
module tb_tlb_set_assoc_array;
  typedef struct packed {logic hit; logic [21:0] ppn; logic [7:0] perms;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 0, fill_valid = 0, fill_global = 0, flush_valid = 0;
  logic [19:0] req_vpn = 0, fill_vpn = 0, flush_vpn = 0;
  logic [8:0] req_asid = 0, fill_asid = 0, flush_asid = 0;
  logic [21:0] fill_ppn = 0;
  logic [7:0] fill_perms = 0;
  logic [1:0] flush_mode = 0;
  logic req_ready, resp_valid, resp_hit, flush_ready, flush_done;
  logic [21:0] resp_ppn;
  logic [7:0] resp_perms;
  logic s_req_valid = 0, s_fill_valid = 0;
  logic [19:0] s_req_vpn = 0, s_fill_vpn = 0;
  logic [21:0] s_fill_ppn = 0;
  logic s_req_ready, s_resp_valid, s_resp_hit, s_flush_ready, s_flush_done;
  logic [21:0] s_resp_ppn;
  logic [7:0] s_resp_perms;
  int vectors = 0, miscompares = 0;
  exp_t q0[$], q1[$];

  tlb_set_assoc_array u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn), .resp_perms(resp_perms),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid), .fill_ppn(fill_ppn),
    .fill_perms(fill_perms), .fill_global(fill_global), .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_mode(flush_mode), .flush_vpn(flush_vpn), .flush_asid(flush_asid), .flush_done(flush_done));

  tlb_set_assoc_array #(.ENTRIES(4), .ASSOC(1), .SUPERPAGE(1)) u_sp (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_vpn(s_req_vpn), .req_asid(9'd0),
    .resp_valid(s_resp_valid), .resp_hit(s_resp_hit), .resp_ppn(s_resp_ppn), .resp_perms(s_resp_perms),
    .fill_valid(s_fill_valid), .fill_vpn(s_fill_vpn), .fill_asid(9'd0), .fill_ppn(s_fill_ppn),
    .fill_perms(8'h5A), .fill_global(1'b0), .flush_valid(1'b0), .flush_ready(s_flush_ready),
    .flush_mode(2'd0), .flush_vpn(20'd0), .flush_asid(9'd0), .flush_done(s_flush_done));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitors pop the expected response whenever a DUT presents one
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q0.size() == 0) check("resp0 unexpected", 64'(resp_valid), 64'd0);
      else check("resp0", 64'({resp_hit, resp_ppn, resp_perms}), 64'(q0.pop_front()));
    end
    if (s_resp_valid) begin
      if (q1.size() == 0) check("resp_sp unexpected", 64'(s_resp_valid), 64'd0);
      else check("resp_sp", 64'({s_resp_hit, s_resp_ppn, s_resp_perms}), 64'(q1.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [19:0] v, input logic [8:0] a, input logic [21:0] p, input logic g);
    fill_valid = 1; fill_vpn = v; fill_asid = a; fill_ppn = p; fill_perms = p[7:0]; fill_global = g;
    tick;
    fill_valid = 0;
  endtask

  task automatic lookup(input logic [19:0] v, input logic [8:0] a, input logic h, input logic [21:0] p);
    exp_t e;
    e = h ? {1'b1, p, p[7:0]} : '0;
    req_valid = 1; req_vpn = v; req_asid = a;
    q0.push_back(e);
    tick;
    req_valid = 0;
    check("resp latency", 64'(resp_valid), 64'd1);
  endtask

  task automatic flush(input logic [1:0] m, input logic [19:0] v, input logic [8:0] a);
    flush_valid = 1; flush_mode = m; flush_vpn = v; flush_asid = a;
    tick;
    flush_valid = 0;
    if (m != 2'd2) check("flush_done", 64'(flush_done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic any_done;
    exp_t e;
    repeat (3) tick;
    rst = 0;
    tick;
    check("reset outputs", 64'({resp_valid, resp_hit, resp_ppn, resp_perms, flush_done}), 64'd0);
    check("reset ready", 64'({req_ready, flush_ready}), 64'd3);
    fill(20'h12345, 9'd3, 22'h2ABCD, 1'b0);
    lookup(20'h12345, 9'd3, 1'b1, 22'h2ABCD);
    lookup(20'h12345, 9'd4, 1'b0, 22'h0);
    flush(2'd0, 20'h0, 9'd0);
    lookup(20'h12345, 9'd3, 1'b0, 22'h0);
    fill(20'h00005, 9'd1, 22'h100, 1'b0);
    fill(20'h00015, 9'd1, 22'h101, 1'b0);
    fill(20'h00025, 9'd1, 22'h102, 1'b0);
    lookup(20'h00005, 9'd1, 1'b0, 22'h0);
    lookup(20'h00015, 9'd1, 1'b1, 22'h101);
    lookup(20'h00025, 9'd1, 1'b1, 22'h102);
    fill(20'h00035, 9'd1, 22'h103, 1'b0);
    lookup(20'h00015, 9'd1, 1'b0, 22'h0);
    lookup(20'h00035, 9'd1, 1'b1, 22'h103);
    fill(20'h00025, 9'd1, 22'h1FF, 1'b0);
    lookup(20'h00025, 9'd1, 1'b1, 22'h1FF);
    lookup(20'h00035, 9'd1, 1'b1, 22'h103);
    fill(20'h00045, 9'd1, 22'h104, 1'b0);
    lookup(20'h00025, 9'd1, 1'b0, 22'h0);
    lookup(20'h00035, 9'd1, 1'b1, 22'h103);
    lookup(20'h00045, 9'd1, 1'b1, 22'h104);
    fill(20'h00100, 9'd1, 22'h200, 1'b1);
    fill(20'h00203, 9'd2, 22'h201, 1'b0);
    flush(2'd2, 20'h0, 9'd2);
    fill_valid = 1; fill_vpn = 20'h00300; fill_asid = 9'd5; fill_ppn = 22'h333; fill_global = 0;
    for (int k = 1; k <= 16; k++) begin
      check("walk busy", 64'({req_ready, flush_ready, flush_done}), 64'd0);
      tick;
    end
    fill_valid = 0;
    check("walk done", 64'({flush_done, flush_ready, req_ready}), 64'd7);
    lookup(20'h00100, 9'd7, 1'b1, 22'h200);
    lookup(20'h00203, 9'd2, 1'b0, 22'h0);
    lookup(20'h00035, 9'd1, 1'b1, 22'h103);
    lookup(20'h00300, 9'd5, 1'b0, 22'h0);
    fill(20'h00404, 9'd3, 22'h210, 1'b0);
    flush(2'd3, 20'h00404, 9'd4);
    lookup(20'h00404, 9'd3, 1'b1, 22'h210);
    flush(2'd3, 20'h00404, 9'd3);
    lookup(20'h00404, 9'd3, 1'b0, 22'h0);
    fill(20'h00505, 9'd3, 22'h220, 1'b1);
    flush(2'd3, 20'h00505, 9'd3);
    lookup(20'h00505, 9'd3, 1'b1, 22'h220);
    flush(2'd1, 20'h00505, 9'd0);
    lookup(20'h00505, 9'd3, 1'b0, 22'h0);
    fill(20'h00606, 9'd1, 22'h300, 1'b0);
    req_valid = 1; req_vpn = 20'h00606; req_asid = 9'd1;
    flush_valid = 1; flush_mode = 2'd0;
    e = {1'b1, 22'h300, 8'h00};
    q0.push_back(e);
    tick;
    req_valid = 0; flush_valid = 0;
    check("same-cycle flush_done", 64'({flush_done, resp_valid}), 64'd3);
    lookup(20'h00606, 9'd1, 1'b0, 22'h0);
    s_fill_valid = 1; s_fill_vpn = 20'h80400; s_fill_ppn = 22'h123000;
    tick;
    s_fill_valid = 0;
    s_req_valid = 1; s_req_vpn = 20'h807FF;
    e = {1'b1, 22'h1233FF, 8'h5A};
    q1.push_back(e);
    tick;
    s_req_vpn = 20'h80800;
    q1.push_back('0);
    tick;
    s_req_valid = 0;
    fill(20'h00707, 9'd1, 22'h377, 1'b0);
    flush(2'd2, 20'h0, 9'd1);
    repeat (3) tick;
    rst = 1;
    #1;
    check("mid-walk reset outputs", 64'({resp_valid, resp_hit, resp_ppn, resp_perms, flush_done}), 64'd0);
    check("mid-walk reset ready", 64'({req_ready, flush_ready}), 64'd3);
    tick;
    rst = 0;
    any_done = 0;
    for (int k = 0; k < 20; k++) begin
      any_done |= flush_done;
      tick;
    end
    check("no flush_done after reset", 64'(any_done), 64'd0);
    check("ready after reset", 64'({req_ready, flush_ready}), 64'd3);
    lookup(20'h00707, 9'd1, 1'b0, 22'h0);
    lookup(20'h00100, 9'd1, 1'b0, 22'h0);
    repeat (2) tick;
    check("q0 drained", 64'(q0.size()), 64'd0);
    check("q1 drained", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
